reg_file_param: RTL and testbench

Parametrised general-purpose register file for the RISC datapath. It has two combinational read ports and one synchronous write port. Write-to-read bypass and an optional hardwired-zero register 0 are built in. A per-register pending scoreboard supports hazard detection. A clear sequencer zeroes the storage after reset or on request, so the array needs no reset and maps to RAM or flops. It sits between decode (read/reserve) and writeback (write).

---
 rtl/reg_file_param.sv | 110 +++++++++++
 tb/tb_reg_file_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// write-to-read bypass, optional hardwired r0, pending scoreboard and clear sweep.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_1,
    input  logic [ADDR_W-1:0] rs_2,
    output logic [DATA_W-1:0] rout_1,
    output logic [DATA_W-1:0] rout_2,
    output logic              pend_1,
    output logic              pend_2,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_address,
    input  logic              clear_req,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DEPTH-1:0]  pending;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              idle_op, write_hit, reserve_hit;

    // A clear request takes priority over any write/reserve in the same cycle.
    always_comb begin
        idle_op     = (state == IDLE) && !clear_req;
        write_hit   = idle_op && write_enable && !(ZERO_REG && write_address == '0);
        reserve_hit = idle_op && reserve_en   && !(ZERO_REG && reserve_address == '0);
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) next_state = IDLE;
            IDLE:    if (clear_req)     next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the later
    // reserve assignment therefore overrides a same-address write clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pending <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            else if (clear_req)
                clr_cnt <= '0;

            if (state == IDLE && clear_req) begin
                pending <= '0;
            end else begin
                if (write_hit)   pending[write_address]   <= 1'b0;
                if (reserve_hit) pending[reserve_address] <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; the clear sweep zeroes it so it can map to RAM.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (write_hit)
            mem[write_address] <= write_data;
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] rs);
        logic [DATA_W-1:0] value;
        value = mem[rs];
        if (state == CLEAR || (ZERO_REG && rs == '0))
            value = '0;
        else if (BYPASS && write_hit && write_address == rs)
            value = write_data;
        return value;
    endfunction

    function automatic logic read_pend(input logic [ADDR_W-1:0] rs);
        logic flag;
        flag = pending[rs];
        if (state == CLEAR || (ZERO_REG && rs == '0))
            flag = 1'b0;
        else if (BYPASS && write_hit && write_address == rs)
            flag = 1'b0;
        return flag;
    endfunction

    always_comb begin
        rout_1 = read_data(rs_1);
        rout_2 = read_data(rs_2);
        pend_1 = read_pend(rs_1);
        pend_2 = read_pend(rs_2);
        busy   = (state == CLEAR);
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (default parameters) against a
// behavioural model holding register contents, pending flags and a clear countdown.
module tb_reg_file_param;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs_1 = '0, rs_2 = '0;
    logic [DW-1:0] rout_1, rout_2;
    logic          pend_1, pend_2;
    logic          write_enable = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] write_data = '0;
    logic          reserve_en = 1'b0;
    logic [AW-1:0] reserve_address = '0;
    logic          clear_req = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem  [DEPTH];
    logic          ref_pend [DEPTH];
    int            clear_left;

    reg_file_param dut (
        .clk(clk), .rst_n(rst_n),
        .rs_1(rs_1), .rs_2(rs_2),
        .rout_1(rout_1), .rout_2(rout_2),
        .pend_1(pend_1), .pend_2(pend_2),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_address(reserve_address),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_wipe();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
        end
        clear_left = DEPTH;
    endfunction

    function automatic logic write_live();
        return clear_left == 0 && !clear_req && write_enable && write_address != 0;
    endfunction

    function automatic logic [DW-1:0] exp_rout(input logic [AW-1:0] rs);
        if (clear_left > 0 || rs == 0) return '0;
        if (write_live() && write_address == rs) return write_data;
        return ref_mem[rs];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] rs);
        if (clear_left > 0 || rs == 0) return 1'b0;
        if (write_live() && write_address == rs) return 1'b0;
        return ref_pend[rs];
    endfunction

    function automatic void model_edge();
        if (clear_left > 0) begin
            clear_left--;
        end else if (clear_req) begin
            model_wipe();
        end else begin
            if (write_enable && write_address != 0) begin
                ref_mem[write_address]  = write_data;
                ref_pend[write_address] = 1'b0;
            end
            if (reserve_en && reserve_address != 0)
                ref_pend[reserve_address] = 1'b1;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        write_enable = 1'b0;
        reserve_en   = 1'b0;
        clear_req    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        chk({tag, ".busy"},   {31'b0, busy},   {31'b0, clear_left > 0});
        chk({tag, ".rout_1"}, rout_1,          exp_rout(rs_1));
        chk({tag, ".rout_2"}, rout_2,          exp_rout(rs_2));
        chk({tag, ".pend_1"}, {31'b0, pend_1}, {31'b0, exp_pend(rs_1)});
        chk({tag, ".pend_2"}, {31'b0, pend_2}, {31'b0, exp_pend(rs_2)});
    endtask

    task automatic sweep_reads(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rs_1 = AW'(a);
            rs_2 = AW'(DEPTH - 1 - a);
            check_outputs(tag);
        end
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            write_enable  = 1'b1;
            write_address = AW'($urandom_range(1, DEPTH - 1));
            write_data    = $urandom;
            reserve_en    = 1'b1;
            reserve_address = AW'($urandom_range(1, DEPTH - 1));
            rs_1 = write_address;
            rs_2 = reserve_address;
            chk({tag, ".busy_lit"}, {31'b0, busy}, 32'd1);
            check_outputs(tag);
            tick();
        end
        quiet();
    endtask

    initial begin
        // Reset held across edges: busy high, outputs zero.
        model_wipe();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.busy_lit", {31'b0, busy}, 32'd1);
        rst_n = 1'b1;

        // Busy for exactly DEPTH edges after release.
        for (int i = 0; i < DEPTH; i++) begin
            check_outputs("init_sweep");
            tick();
        end
        chk("init_done.busy_lit", {31'b0, busy}, 32'd0);
        sweep_reads("init_read");

        // Bypass and persistence.
        write_enable = 1'b1; write_address = 5'd7; write_data = 32'hDEADBEEF; rs_1 = 5'd7;
        check_outputs("bypass");
        chk("bypass.lit", rout_1, 32'hDEADBEEF);
        tick();
        quiet();
        check_outputs("after_write");
        chk("after_write.lit", rout_1, 32'hDEADBEEF);

        // Hardwired zero register.
        write_enable = 1'b1; write_address = 5'd0; write_data = 32'h12345678; rs_1 = 5'd0;
        check_outputs("r0_write");
        tick();
        quiet();
        check_outputs("r0_after");
        reserve_en = 1'b1; reserve_address = 5'd0;
        tick();
        quiet();
        check_outputs("r0_reserve");
        chk("r0_reserve.lit", {31'b0, pend_1}, 32'd0);

        // Scoreboard.
        reserve_en = 1'b1; reserve_address = 5'd5; rs_2 = 5'd5;
        tick();
        quiet();
        check_outputs("reserve_r5");
        chk("reserve_r5.lit", {31'b0, pend_2}, 32'd1);
        write_enable = 1'b1; write_address = 5'd5; write_data = 32'h55;
        check_outputs("write_r5");
        chk("write_r5.lit", {31'b0, pend_2}, 32'd0);
        tick();
        quiet();
        check_outputs("write_r5_after");
        write_enable = 1'b1; write_address = 5'd9; write_data = 32'hA5A5_0009;
        reserve_en = 1'b1; reserve_address = 5'd9;
        tick();
        quiet();
        rs_1 = 5'd9; rs_2 = 5'd9;
        check_outputs("wr_res_r9");
        chk("wr_res_r9.data", rout_1, 32'hA5A5_0009);
        chk("wr_res_r9.pend", {31'b0, pend_2}, 32'd1);

        // Fill r1..r31, then clear with a colliding write.
        for (int a = 1; a < DEPTH; a++) begin
            write_enable = 1'b1; write_address = AW'(a); write_data = DW'(a);
            tick();
        end
        quiet();
        sweep_reads("filled");
        clear_req = 1'b1; write_enable = 1'b1; write_address = 5'd3; write_data = 32'hABCD;
        rs_1 = 5'd3;
        check_outputs("clear_req");
        tick();
        quiet();
        run_clear("clear_busy");
        chk("clear_done.busy_lit", {31'b0, busy}, 32'd0);
        sweep_reads("clear_read");

        // Reset in the middle of a sweep restarts a full-length sweep.
        for (int a = 1; a < DEPTH; a += 3) begin
            write_enable = 1'b1; write_address = AW'(a); write_data = $urandom;
            tick();
        end
        quiet();
        clear_req = 1'b1;
        tick();
        quiet();
        repeat (10) tick();
        rst_n = 1'b0;
        model_wipe();
        #2;
        check_outputs("mid_reset");
        rst_n = 1'b1;
        #1;
        run_clear("mid_reset_sweep");
        chk("mid_reset_done.busy_lit", {31'b0, busy}, 32'd0);
        sweep_reads("mid_reset_read");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rs_1            = AW'($urandom_range(0, 7));
            rs_2            = AW'($urandom_range(0, 7));
            write_enable    = 1'($urandom_range(0, 1));
            write_address   = AW'($urandom_range(0, 7));
            write_data      = $urandom;
            reserve_en      = 1'($urandom_range(0, 1));
            reserve_address = AW'($urandom_range(0, 7));
            clear_req       = ($urandom_range(0, 59) == 0);
            check_outputs("random");
            tick();
        end
        quiet();
        check_outputs("random_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
